// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-core data-memory arbiter.
// State encodings, core identifiers and the default datapath width live here.
package data_mem_arbiter_pkg;

  localparam int REG_WIDTH_DEF = 16;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // The round-robin pointer always moves to the core that did not just win.
  function automatic logic other_core(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter.
// A lone requester always wins; on a tie the core named by rr wins.
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic       gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = CORE0;
    case (req)
      2'b01:   gnt_id = CORE0;
      2'b10:   gnt_id = CORE1;
      2'b11:   gnt_id = rr;
      default: gnt_id = CORE0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises the two cores' data-memory accesses onto one shared memory port,
// returning registered read data and a one-cycle done pulse per transaction.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int reg_width   = REG_WIDTH_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 c0_req,
  input  logic                 c0_we,
  input  logic [reg_width-1:0] c0_addr,
  input  logic [reg_width-1:0] c0_wdata,
  output logic [reg_width-1:0] c0_rdata,
  output logic                 c0_done,

  input  logic                 c1_req,
  input  logic                 c1_we,
  input  logic [reg_width-1:0] c1_addr,
  input  logic [reg_width-1:0] c1_wdata,
  output logic [reg_width-1:0] c1_rdata,
  output logic                 c1_done,

  output logic                 mem_en,
  output logic                 mem_we,
  output logic [reg_width-1:0] mem_addr,
  output logic [reg_width-1:0] mem_wdata,
  input  logic [reg_width-1:0] mem_rdata,

  output logic                 busy,
  output logic                 grant_id
);

  // WAIT lasts MEM_LATENCY cycles; the counter runs 0 .. MEM_LATENCY-1.
  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 rr_q, rr_d;
  logic                 we_q, we_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [reg_width-1:0] mem_addr_q, mem_addr_d;
  logic [reg_width-1:0] mem_wdata_q, mem_wdata_d;
  logic [reg_width-1:0] c0_rdata_q, c0_rdata_d;
  logic [reg_width-1:0] c1_rdata_q, c1_rdata_d;
  logic                 c0_done_q, c0_done_d;
  logic                 c1_done_q, c1_done_d;

  logic                 arb_id;
  logic                 arb_valid;

  rr_arb2 u_rr_arb2 (
    .req       ({c1_req, c0_req}),
    .rr        (rr_q),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c0_rdata_d  = c0_rdata_q;
    c1_rdata_d  = c1_rdata_q;
    c0_done_d   = 1'b0;
    c1_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Request fields are sampled only here; later changes are ignored.
        if (arb_valid) begin
          state_d     = ST_ACCESS;
          gnt_d       = arb_id;
          rr_d        = other_core(arb_id);
          we_d        = (arb_id == CORE1) ? c1_we    : c0_we;
          mem_addr_d  = (arb_id == CORE1) ? c1_addr  : c0_addr;
          mem_wdata_d = (arb_id == CORE1) ? c1_wdata : c0_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = (arb_id == CORE1) ? c1_we    : c0_we;
        end
      end

      ST_ACCESS: begin
        if (we_q) begin
          state_d   = ST_DONE;
          c0_done_d = (gnt_q == CORE0);
          c1_done_d = (gnt_q == CORE1);
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 3'd0;
        end
      end

      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d   = ST_DONE;
          c0_done_d = (gnt_q == CORE0);
          c1_done_d = (gnt_q == CORE1);
          if (gnt_q == CORE1) begin
            c1_rdata_d = mem_rdata;
          end else begin
            c0_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= CORE0;
      rr_q        <= CORE0;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c0_rdata_q  <= '0;
      c1_rdata_q  <= '0;
      c0_done_q   <= 1'b0;
      c1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_done_q   <= c0_done_d;
      c1_done_q   <= c1_done_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;
  assign c0_done   = c0_done_q;
  assign c1_done   = c1_done_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = (state_q == ST_IDLE) ? CORE0 : gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter: a MEM_LATENCY=1 instance
// backed by a small memory model, plus a MEM_LATENCY=3 instance with hand-driven read data.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;

  logic        c0_req, c0_we, c1_req, c1_we;
  logic [15:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic [15:0] c0_rdata, c1_rdata;
  logic        c0_done, c1_done;
  logic        mem_en, mem_we, busy, grant_id;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        d3_c0_req, d3_c0_we, d3_c1_req, d3_c1_we;
  logic [15:0] d3_c0_addr, d3_c0_wdata, d3_c1_addr, d3_c1_wdata;
  logic [15:0] d3_c0_rdata, d3_c1_rdata;
  logic        d3_c0_done, d3_c1_done;
  logic        d3_mem_en, d3_mem_we, d3_busy, d3_grant_id;
  logic [15:0] d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [0:255];
  logic [15:0] rd_pipe;

  data_mem_arbiter #(.reg_width(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_done(c0_done),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_done(c1_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  data_mem_arbiter #(.reg_width(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .c0_req(d3_c0_req), .c0_we(d3_c0_we), .c0_addr(d3_c0_addr), .c0_wdata(d3_c0_wdata),
    .c0_rdata(d3_c0_rdata), .c0_done(d3_c0_done),
    .c1_req(d3_c1_req), .c1_we(d3_c1_we), .c1_addr(d3_c1_addr), .c1_wdata(d3_c1_wdata),
    .c1_rdata(d3_c1_rdata), .c1_done(d3_c1_done),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata), .busy(d3_busy), .grant_id(d3_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
      else        rd_pipe <= mem_model[mem_addr[7:0]];
    end
  end
  assign mem_rdata = rd_pipe;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic core, input logic req, input logic we,
                               input logic [15:0] addr, input logic [15:0] wdata);
    if (core) begin
      c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wdata;
    end else begin
      c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wdata;
    end
  endtask

  logic        grant_log [0:4];
  int          grants_seen;
  int          c1_reads;
  int          cyc;

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    d3_c0_req = 1'b0; d3_c0_we = 1'b0; d3_c0_addr = 16'h0; d3_c0_wdata = 16'h0;
    d3_c1_req = 1'b0; d3_c1_we = 1'b0; d3_c1_addr = 16'h0; d3_c1_wdata = 16'h0;
    d3_mem_rdata = 16'h0;
    repeat (2) tick();

    $display("[TB] reset and idle");
    checkOutput("rst_mem_en",    16'(mem_en),    16'h0);
    checkOutput("rst_mem_we",    16'(mem_we),    16'h0);
    checkOutput("rst_mem_addr",  mem_addr,       16'h0);
    checkOutput("rst_mem_wdata", mem_wdata,      16'h0);
    checkOutput("rst_c0_done",   16'(c0_done),   16'h0);
    checkOutput("rst_c1_done",   16'(c1_done),   16'h0);
    checkOutput("rst_c0_rdata",  c0_rdata,       16'h0);
    checkOutput("rst_c1_rdata",  c1_rdata,       16'h0);
    checkOutput("rst_busy",      16'(busy),      16'h0);
    checkOutput("rst_grant_id",  16'(grant_id),  16'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("idle_mem_en", 16'(mem_en), 16'h0);
      checkOutput("idle_busy",   16'(busy),   16'h0);
    end

    $display("[TB] simultaneous requests after reset");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0030, 16'h2222);
    tick();
    checkOutput("t3_a_mem_en",   16'(mem_en),   16'h1);
    checkOutput("t3_a_grant",    16'(grant_id), 16'h0);
    checkOutput("t3_a_mem_addr", mem_addr,      16'h0020);
    checkOutput("t3_a_wdata",    mem_wdata,     16'h1111);
    tick();
    checkOutput("t3_a_c0_done",  16'(c0_done),  16'h1);
    checkOutput("t3_a_c1_done",  16'(c1_done),  16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    checkOutput("t3_idle_busy",  16'(busy),     16'h0);
    checkOutput("t3_idle_grant", 16'(grant_id), 16'h0);
    tick();
    checkOutput("t3_b_mem_en",   16'(mem_en),   16'h1);
    checkOutput("t3_b_grant",    16'(grant_id), 16'h1);
    checkOutput("t3_b_mem_addr", mem_addr,      16'h0030);
    checkOutput("t3_b_wdata",    mem_wdata,     16'h2222);
    tick();
    checkOutput("t3_b_c1_done",  16'(c1_done),  16'h1);
    c1_req = 1'b0;
    tick();
    checkOutput("t3_idle2_busy", 16'(busy),     16'h0);
    tick();
    checkOutput("t3_c_grant",    16'(grant_id), 16'h0);
    checkOutput("t3_c_mem_we",   16'(mem_we),   16'h0);
    checkOutput("t3_c_mem_addr", mem_addr,      16'h0020);
    tick();
    checkOutput("t3_c_wait_busy", 16'(busy),    16'h1);
    checkOutput("t3_c_wait_done", 16'(c0_done), 16'h0);
    tick();
    checkOutput("t3_c_c0_done",  16'(c0_done),  16'h1);
    checkOutput("t3_c_c0_rdata", c0_rdata,      16'h1111);
    checkOutput("t3_c_c1_rdata", c1_rdata,      16'h0);
    c0_req = 1'b0;
    tick();

    $display("[TB] core 0 write then read");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    tick();
    checkOutput("t2_mem_en",    16'(mem_en),  16'h1);
    checkOutput("t2_mem_we",    16'(mem_we),  16'h1);
    checkOutput("t2_mem_addr",  mem_addr,     16'h0010);
    checkOutput("t2_mem_wdata", mem_wdata,    16'hBEEF);
    checkOutput("t2_c0_done_early", 16'(c0_done), 16'h0);
    c0_addr = 16'h9999;
    c0_wdata = 16'h0000;
    tick();
    checkOutput("t2_c0_done",   16'(c0_done), 16'h1);
    checkOutput("t2_mem_en_off", 16'(mem_en), 16'h0);
    checkOutput("t2_addr_held", mem_addr,     16'h0010);
    c0_req = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    checkOutput("t2_rd_mem_en", 16'(mem_en),  16'h1);
    checkOutput("t2_rd_mem_we", 16'(mem_we),  16'h0);
    tick();
    checkOutput("t2_rd_wait_done", 16'(c0_done), 16'h0);
    tick();
    checkOutput("t2_rd_done",   16'(c0_done), 16'h1);
    checkOutput("t2_rd_rdata",  c0_rdata,     16'hBEEF);
    checkOutput("t2_rd_c1_hold", c1_rdata,    16'h0);
    c0_req = 1'b0;
    tick();

    $display("[TB] core 1 streaming reads with one core 0 read");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    grants_seen = 0;
    c1_reads = 0;
    cyc = 0;
    while ((c1_reads < 4 || c0_req) && cyc < 60) begin
      tick();
      cyc++;
      if (mem_en) begin
        if (grants_seen < 5) grant_log[grants_seen] = grant_id;
        grants_seen++;
        if (grants_seen == 1) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
      end
      if (c0_done) begin
        c0_req = 1'b0;
        checkOutput("t4_c0_rdata", c0_rdata, 16'hBEEF);
      end
      if (c1_done) begin
        c1_reads++;
        checkOutput("t4_c1_rdata", c1_rdata, 16'h2222);
        if (c1_reads == 4) c1_req = 1'b0;
      end
    end
    checkOutput("t4_in_budget", 16'(cyc < 60), 16'h1);
    checkOutput("t4_grant_count", 16'(grants_seen), 16'd5);
    if (grants_seen >= 5) begin
      checkOutput("t4_grant0", 16'(grant_log[0]), 16'h1);
      checkOutput("t4_grant1", 16'(grant_log[1]), 16'h0);
      checkOutput("t4_grant2", 16'(grant_log[2]), 16'h1);
      checkOutput("t4_grant3", 16'(grant_log[3]), 16'h1);
      checkOutput("t4_grant4", 16'(grant_log[4]), 16'h1);
    end
    tick();

    $display("[TB] latency-3 read on second instance");
    d3_c1_req = 1'b1; d3_c1_we = 1'b0; d3_c1_addr = 16'h0077;
    tick();
    checkOutput("t5_mem_en",   16'(d3_mem_en),   16'h1);
    checkOutput("t5_grant",    16'(d3_grant_id), 16'h1);
    checkOutput("t5_mem_addr", d3_mem_addr,      16'h0077);
    d3_mem_rdata = 16'hAAAA;
    tick();
    checkOutput("t5_done_t2",  16'(d3_c1_done),  16'h0);
    d3_mem_rdata = 16'hBBBB;
    tick();
    d3_mem_rdata = 16'hCCCC;
    tick();
    checkOutput("t5_done_t4",  16'(d3_c1_done),  16'h0);
    checkOutput("t5_busy_t4",  16'(d3_busy),     16'h1);
    d3_mem_rdata = 16'h5A5A;
    tick();
    checkOutput("t5_done_t5",  16'(d3_c1_done),  16'h1);
    checkOutput("t5_rdata",    d3_c1_rdata,      16'h5A5A);
    d3_mem_rdata = 16'hDDDD;
    d3_c1_req = 1'b0;
    tick();
    checkOutput("t5_done_off", 16'(d3_c1_done),  16'h0);
    checkOutput("t5_rdata_hold", d3_c1_rdata,    16'h5A5A);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    tick();
    checkOutput("t6_mem_en", 16'(mem_en), 16'h1);
    tick();
    checkOutput("t6_wait_busy", 16'(busy), 16'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_rst_mem_en",   16'(mem_en),   16'h0);
    checkOutput("t6_rst_busy",     16'(busy),     16'h0);
    checkOutput("t6_rst_grant",    16'(grant_id), 16'h0);
    checkOutput("t6_rst_c1_done",  16'(c1_done),  16'h0);
    checkOutput("t6_rst_c0_rdata", c0_rdata,      16'h0);
    checkOutput("t6_rst_mem_addr", mem_addr,      16'h0);
    c1_req = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_done", 16'(c1_done), 16'h0);
      checkOutput("t6_idle",    16'(busy),    16'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0050, 16'h3333);
    tick();
    checkOutput("t6_new_mem_en", 16'(mem_en),  16'h1);
    checkOutput("t6_new_addr",   mem_addr,     16'h0050);
    tick();
    checkOutput("t6_new_done",   16'(c0_done), 16'h1);
    c0_req = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0);
    repeat (3) tick();
    checkOutput("t6_rd_done",    16'(c0_done), 16'h1);
    checkOutput("t6_rd_rdata",   c0_rdata,     16'h3333);
    c0_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
